// File: rtl/clb_gen_pkg.sv
// clb_gen_pkg: shared definitions for the parametrised CLB.
//   state_e      : configuration FSM states (ERR only reachable when
//                  CLB_CFG_PARITY_EN is defined)
//   slice_bits() : config bits per slice for a given LUT width
//   fb_ofs(), init_ofs(), osel_ofs() : bit offsets of the control fields
//                  inside one slice's config word (LUT truth table at [2**K-1:0])
package clb_gen_pkg;

  typedef enum logic [2:0] {
    UNCFG  = 3'd0,
    SHIFT  = 3'd1,
    COMMIT = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } state_e;

  function automatic int slice_bits(input int k);
    return (1 << k) + 3;
  endfunction

  function automatic int fb_ofs(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int init_ofs(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int osel_ofs(input int k);
    return (1 << k);
  endfunction

endpackage

// File: rtl/clb_gen_if.sv
// clb_gen_if: logic-side and configuration-side signals of one CLB.
//   IN       : LUT inputs, slice i uses IN[i*LUT_K +: LUT_K]
//   CE / SR  : per-slice flop enable / synchronous load of ff_init
//   CFG_EN, CFG_DIN : serial config shift enable and data
//   CFG_DOUT : shadow MSB, daisy-chains to the next CLB
//   CFG_DONE : high while running a committed configuration
//   OUT / Q  : slice outputs / raw flop outputs
//   CFG_ERR  : parity error flag (only with CLB_CFG_PARITY_EN)
// Modports: master drives the inputs (fabric/bench), slave is the CLB.
interface clb_gen_if #(
  parameter int LUT_K     = 4,
  parameter int NUM_SLICE = 2
);
  logic [NUM_SLICE*LUT_K-1:0] IN;
  logic [NUM_SLICE-1:0]       CE;
  logic [NUM_SLICE-1:0]       SR;
  logic                       CFG_EN;
  logic                       CFG_DIN;
  logic                       CFG_DOUT;
  logic                       CFG_DONE;
  logic [NUM_SLICE-1:0]       OUT;
  logic [NUM_SLICE-1:0]       Q;
`ifdef CLB_CFG_PARITY_EN
  logic                       CFG_ERR;

  modport master (output IN, CE, SR, CFG_EN, CFG_DIN,
                  input  CFG_DOUT, CFG_DONE, OUT, Q, CFG_ERR);
  modport slave  (input  IN, CE, SR, CFG_EN, CFG_DIN,
                  output CFG_DOUT, CFG_DONE, OUT, Q, CFG_ERR);
`else
  modport master (output IN, CE, SR, CFG_EN, CFG_DIN,
                  input  CFG_DOUT, CFG_DONE, OUT, Q);
  modport slave  (input  IN, CE, SR, CFG_EN, CFG_DIN,
                  output CFG_DOUT, CFG_DONE, OUT, Q);
`endif
endinterface

// File: rtl/clb_slice.sv
// clb_slice: one LUT_K-input LUT, a storage flop and the output mux.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   cfg_i         : this slice's active config word
//   init_new_i    : ff_init of the config being committed
//   in_i          : LUT inputs
//   ce_i, sr_i    : flop enable / synchronous load of ff_init (SR wins)
//   run_i         : flop may follow ce_i/sr_i this cycle
//   load_i        : commit cycle, flop takes init_new_i
//   out_o, q_o    : slice output, raw flop output
module clb_slice
  import clb_gen_pkg::*;
#(
  parameter int LUT_K = 4,
  localparam int SB   = slice_bits(LUT_K)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SB-1:0]    cfg_i,
  input  logic             init_new_i,
  input  logic [LUT_K-1:0] in_i,
  input  logic             ce_i,
  input  logic             sr_i,
  input  logic             run_i,
  input  logic             load_i,
  output logic             out_o,
  output logic             q_o
);
  localparam int LUT_N = 1 << LUT_K;

  logic [LUT_N-1:0] lut;
  logic             fb_sel, ff_init, out_sel;
  logic [LUT_K-1:0] addr;
  logic             lut_out;
  logic             q_q, q_d;

  assign lut     = cfg_i[LUT_N-1:0];
  assign fb_sel  = cfg_i[fb_ofs(LUT_K)];
  assign ff_init = cfg_i[init_ofs(LUT_K)];
  assign out_sel = cfg_i[osel_ofs(LUT_K)];

  // Feedback replaces the top address bit with the flop, giving
  // toggles/counters without external wiring.
  always_comb begin
    addr = in_i;
    if (fb_sel) addr[LUT_K-1] = q_q;
  end

  assign lut_out = lut[addr];

  always_comb begin
    q_d = q_q;
    if (load_i)     q_d = init_new_i;
    else if (run_i) begin
      if (sr_i)      q_d = ff_init;
      else if (ce_i) q_d = lut_out;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign q_o   = q_q;
  assign out_o = out_sel ? q_q : lut_out;

endmodule

// File: rtl/clb_gen.sv
// clb_gen: parametrised CLB with NUM_SLICE slices and serial configuration.
//   K, RSTN : clock (rising edge), synchronous active-low reset
//   bus     : clb_gen_if slave modport (logic inputs/outputs, config chain)
// Config is shifted MSB-first into a shadow register and copied to the
// active register in a single COMMIT cycle, so slices never see a partial
// configuration. An unconfigured device has an all-zero active word, which
// by itself forces OUT=0 and keeps Q at 0.
// Optional macro CLB_CFG_PARITY_EN: stream gains a trailing even-parity bit,
// a mismatch lands in ERR (CFG_ERR=1) with the old configuration kept.
module clb_gen
  import clb_gen_pkg::*;
#(
  parameter int LUT_K     = 4,
  parameter int NUM_SLICE = 2
) (
  input  logic K,
  input  logic RSTN,
  clb_gen_if.slave bus
);
  localparam int SB       = slice_bits(LUT_K);
  localparam int CFG_BITS = NUM_SLICE * SB;
`ifdef CLB_CFG_PARITY_EN
  localparam int STREAM_LEN = CFG_BITS + 1;
`else
  localparam int STREAM_LEN = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(STREAM_LEN);

  state_e                state_q, state_d, origin_q, origin_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STREAM_LEN-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   active_q, active_d, cfg_img;
  logic                  commit_ok, load_init, slice_run;
  logic [NUM_SLICE-1:0]  out_w, q_w;

  // Config image sits in the top CFG_BITS of the shadow; the parity bit,
  // when present, is the last one shifted in (bit 0).
  assign cfg_img = shadow_q[STREAM_LEN-1 -: CFG_BITS];
`ifdef CLB_CFG_PARITY_EN
  assign commit_ok = ~^shadow_q;
`else
  assign commit_ok = 1'b1;
`endif

  assign shadow_d = bus.CFG_EN ? {shadow_q[STREAM_LEN-2:0], bus.CFG_DIN} : shadow_q;

  always_comb begin
    state_d   = state_q;
    origin_d  = origin_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    load_init = 1'b0;
    case (state_q)
      UNCFG, RUN, ERR: begin
        if (bus.CFG_EN) begin
          state_d  = SHIFT;
          origin_d = state_q;
          cnt_d    = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (bus.CFG_EN) begin
          if (cnt_q == CNT_W'(STREAM_LEN - 1)) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Abort: fall back to wherever the shift started.
          state_d = origin_q;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        cnt_d = '0;
        if (commit_ok) begin
          active_d  = cfg_img;
          load_init = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge K) begin
    if (!RSTN) begin
      state_q  <= UNCFG;
      origin_q <= UNCFG;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      origin_q <= origin_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // The old configuration keeps running while a reload shifts in.
  assign slice_run = (state_q == RUN) || ((state_q == SHIFT) && (origin_q == RUN));

  for (genvar i = 0; i < NUM_SLICE; i++) begin : g_slice
    clb_slice #(.LUT_K(LUT_K)) u_slice (
      .clk_i      (K),
      .rst_ni     (RSTN),
      .cfg_i      (active_q[i*SB +: SB]),
      .init_new_i (cfg_img[i*SB + init_ofs(LUT_K)]),
      .in_i       (bus.IN[i*LUT_K +: LUT_K]),
      .ce_i       (bus.CE[i]),
      .sr_i       (bus.SR[i]),
      .run_i      (slice_run),
      .load_i     (load_init),
      .out_o      (out_w[i]),
      .q_o        (q_w[i])
    );
  end

  assign bus.OUT      = out_w;
  assign bus.Q        = q_w;
  assign bus.CFG_DOUT = shadow_q[STREAM_LEN-1];
  assign bus.CFG_DONE = (state_q == RUN);
`ifdef CLB_CFG_PARITY_EN
  assign bus.CFG_ERR  = (state_q == ERR);
`endif

endmodule

// File: tb/tb_clb_gen.sv
// tb_clb_gen: table vectors, hand-written corner sequences and randomized
// traffic for clb_gen, checked every cycle against a stream/queue model.
module tb_clb_gen;
  import clb_gen_pkg::*;

  localparam int LUT_K     = 4;
  localparam int NUM_SLICE = 2;
  localparam int SB        = slice_bits(LUT_K);
  localparam int CFG_BITS  = NUM_SLICE * SB;
  localparam int INW       = NUM_SLICE * LUT_K;
  localparam int FB        = fb_ofs(LUT_K);
  localparam int INIT      = init_ofs(LUT_K);
  localparam int OSEL      = osel_ofs(LUT_K);
`ifdef CLB_CFG_PARITY_EN
  localparam int LEN = CFG_BITS + 1;
`else
  localparam int LEN = CFG_BITS;
`endif

  logic K = 1'b0;
  logic RSTN;
  always #5 K = ~K;

  clb_gen_if #(.LUT_K(LUT_K), .NUM_SLICE(NUM_SLICE)) bus ();
  clb_gen #(.LUT_K(LUT_K), .NUM_SLICE(NUM_SLICE)) dut (.K(K), .RSTN(RSTN), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // mode: 0 never configured, 1 running, 2 parity error
  logic [CFG_BITS-1:0]  m_act   = '0;
  logic [NUM_SLICE-1:0] m_q     = '0;
  int                   m_mode  = 0;
  int                   m_burst = 0;   // consecutive CFG_EN cycles in current load
  bit                   m_pend  = 0;   // next edge commits
  bit                   m_hist[$];     // last LEN shifted bits, oldest first
  logic [LEN-1:0]       last_stream = '0;

  function automatic logic m_lut(input int i);
    logic [SB-1:0] f;
    int half, a;
    f    = m_act[i*SB +: SB];
    half = 1 << (LUT_K - 1);
    a    = int'(bus.IN[i*LUT_K +: LUT_K]);
    if (f[FB]) a = (a % half) + (m_q[i] ? half : 0);
    return f[a];
  endfunction

  function automatic logic m_out(input int i);
    return m_act[i*SB + OSEL] ? m_q[i] : m_lut(i);
  endfunction

  function automatic logic [LEN-1:0] m_stream();
    logic [LEN-1:0] s;
    s = '0;
    for (int j = 0; j < m_hist.size(); j++) s[m_hist.size()-1-j] = m_hist[j];
    return s;
  endfunction

  task automatic model_edge();
    logic [NUM_SLICE-1:0] nq;
    logic [LEN-1:0]       s;
    bit                   ok;
    if (!RSTN) begin
      m_act = '0; m_q = '0; m_mode = 0; m_burst = 0; m_pend = 0;
      m_hist.delete();
      return;
    end
    nq = m_q;
    if (m_pend) begin
      s  = m_stream();
      ok = 1;
`ifdef CLB_CFG_PARITY_EN
      ok = (^s == 1'b0);
`endif
      if (ok) begin
        m_act = s[LEN-1 -: CFG_BITS];
        for (int i = 0; i < NUM_SLICE; i++) nq[i] = m_act[i*SB + INIT];
        m_mode = 1;
      end else begin
        m_mode = 2;
      end
      m_pend = 0;
    end else begin
      if (m_mode == 1)
        for (int i = 0; i < NUM_SLICE; i++) begin
          if (bus.SR[i])      nq[i] = m_act[i*SB + INIT];
          else if (bus.CE[i]) nq[i] = m_lut(i);
        end
      if (bus.CFG_EN) begin
        m_burst++;
        if (m_burst == LEN) begin m_pend = 1; m_burst = 0; end
      end else begin
        m_burst = 0;
      end
    end
    m_q = nq;
    if (bus.CFG_EN) begin
      m_hist.push_back(bus.CFG_DIN);
      if (m_hist.size() > LEN) void'(m_hist.pop_front());
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NUM_SLICE-1:0] eo;
    for (int i = 0; i < NUM_SLICE; i++) eo[i] = m_out(i);
    chk("out",  bus.OUT, eo);
    chk("q",    bus.Q, m_q);
    chk("done", bus.CFG_DONE, (m_mode == 1 && m_burst == 0 && !m_pend));
    chk("dout", bus.CFG_DOUT, (m_hist.size() == LEN) ? m_hist[0] : 1'b0);
`ifdef CLB_CFG_PARITY_EN
    chk("err",  bus.CFG_ERR, (m_mode == 2 && m_burst == 0 && !m_pend));
`endif
  endtask

  task automatic cyc();
    @(posedge K);
    model_edge();
    #1;
    check_all();
  endtask

  // Full load; stream sent MSB of img first. chk_dout: shadow is known to
  // hold last_stream, so CFG_DOUT must replay it bit by bit.
  task automatic load_cfg(input logic [CFG_BITS-1:0] img, input bit bad, input bit chk_dout);
    logic [LEN-1:0] s;
`ifdef CLB_CFG_PARITY_EN
    s = {img, (^img) ^ bad};
`else
    s = img;
`endif
    for (int k = 0; k < LEN; k++) begin
      bus.CFG_EN  = 1'b1;
      bus.CFG_DIN = s[LEN-1-k];
      cyc();
      if (chk_dout)
        chk("dout_delay", bus.CFG_DOUT, (k + 1 < LEN) ? last_stream[LEN-2-k] : s[LEN-1]);
      if (k == LEN - 1) chk("done_last_bit", bus.CFG_DONE, 1'b0);
    end
    bus.CFG_EN = 1'b0;
    cyc();
    if (!bad) chk("done_after_commit", bus.CFG_DONE, 1'b1);
    last_stream = s;
  endtask

  task automatic abort_shift(input int n);
    for (int k = 0; k < n; k++) begin
      bus.CFG_EN  = 1'b1;
      bus.CFG_DIN = 1'($urandom());
      cyc();
    end
    bus.CFG_EN = 1'b0;
    cyc();
  endtask

  function automatic logic [CFG_BITS-1:0] mk_img(
      input logic fb0, input logic in0, input logic os0, input logic [15:0] l0,
      input logic fb1, input logic in1, input logic os1, input logic [15:0] l1);
    logic [CFG_BITS-1:0] img;
    img = '0;
    img[0*SB +: 16] = l0; img[0*SB+FB] = fb0; img[0*SB+INIT] = in0; img[0*SB+OSEL] = os0;
    img[1*SB +: 16] = l1; img[1*SB+FB] = fb1; img[1*SB+INIT] = in1; img[1*SB+OSEL] = os1;
    return img;
  endfunction

  typedef struct {
    logic [INW-1:0]       in;
    logic [NUM_SLICE-1:0] ce, sr, exp_out, exp_q;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [CFG_BITS-1:0] img_a, img_b, img_r;
    // Config A: slice0 combinational lut 0116; slice1 AND4, registered, init 1
    img_a = mk_img(1'b0, 1'b0, 1'b0, 16'h0116, 1'b0, 1'b1, 1'b1, 16'h8000);
    // Config B: slice0 toggles through feedback (lut = ~addr MSB)
    img_b = mk_img(1'b1, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0000);

    //           in      ce     sr     out    q
    vt[0] = '{8'h04, 2'b00, 2'b00, 2'b11, 2'b10};
    vt[1] = '{8'h06, 2'b00, 2'b00, 2'b10, 2'b10};
    vt[2] = '{8'h70, 2'b10, 2'b00, 2'b00, 2'b00};
    vt[3] = '{8'hF0, 2'b00, 2'b00, 2'b00, 2'b00};
    vt[4] = '{8'hF0, 2'b10, 2'b00, 2'b10, 2'b10};
    vt[5] = '{8'h70, 2'b00, 2'b00, 2'b10, 2'b10};
    vt[6] = '{8'h71, 2'b10, 2'b10, 2'b11, 2'b10};
    vt[7] = '{8'h72, 2'b11, 2'b00, 2'b01, 2'b01};
    vt[8] = '{8'h08, 2'b01, 2'b01, 2'b01, 2'b00};

    // Reset then idle
    RSTN = 1'b0;
    bus.IN = '0; bus.CE = '0; bus.SR = '0; bus.CFG_EN = 1'b0; bus.CFG_DIN = 1'b0;
    cyc(); cyc();
    chk("rst_out", bus.OUT, 2'b00);
    chk("rst_q", bus.Q, 2'b00);
    chk("rst_done", bus.CFG_DONE, 1'b0);
    chk("rst_dout", bus.CFG_DOUT, 1'b0);
    RSTN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.IN = INW'($urandom()); bus.CE = NUM_SLICE'($urandom()); bus.SR = NUM_SLICE'($urandom());
      cyc();
      chk("uncfg_out", bus.OUT, 2'b00);
      chk("uncfg_q", bus.Q, 2'b00);
    end

    // Combinational / registered config
    bus.CE = '0; bus.SR = '0; bus.IN = '0;
    load_cfg(img_a, 1'b0, 1'b1);
    chk("q1_init_after_commit", bus.Q[1], 1'b1);
    foreach (vt[i]) begin
      bus.IN = vt[i].in; bus.CE = vt[i].ce; bus.SR = vt[i].sr;
      cyc();
      chk("tbl_out", bus.OUT, vt[i].exp_out);
      chk("tbl_q", bus.Q, vt[i].exp_q);
    end

    // Feedback toggle
    bus.IN = '0; bus.CE = '0; bus.SR = '0;
    load_cfg(img_b, 1'b0, 1'b1);
    bus.CE = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("toggle", bus.OUT[0], logic'(k % 2 == 0));
    end

    // Full reload while the old function keeps toggling
    load_cfg(img_a, 1'b0, 1'b1);
    bus.IN = 8'h04; bus.CE = '0;
    cyc();
    chk("reload_out", bus.OUT, 2'b11);

    // Abort from RUN after 20 bits
    abort_shift(20);
    chk("abort_done", bus.CFG_DONE, 1'b1);
    chk("abort_out", bus.OUT, 2'b11);
    chk("abort_q", bus.Q, 2'b10);

`ifdef CLB_CFG_PARITY_EN
    load_cfg(img_b, 1'b1, 1'b0);
    chk("par_err", bus.CFG_ERR, 1'b1);
    chk("par_err_done", bus.CFG_DONE, 1'b0);
    chk("par_err_out", bus.OUT, 2'b11);
    load_cfg(img_b, 1'b0, 1'b0);
    chk("par_ok_err", bus.CFG_ERR, 1'b0);
    chk("par_ok_done", bus.CFG_DONE, 1'b1);
`endif

    // Random configurations and traffic
    for (int r = 0; r < 5; r++) begin
      img_r = CFG_BITS'({$urandom(), $urandom()});
      load_cfg(img_r, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
        bus.IN = INW'($urandom()); bus.CE = NUM_SLICE'($urandom()); bus.SR = NUM_SLICE'($urandom());
        if (k == 20 && r[0]) abort_shift($urandom_range(1, LEN - 1));
        else cyc();
      end
    end

    // Reset in the middle of a shift
    bus.CE = '0; bus.SR = '0;
    for (int k = 0; k < 10; k++) begin
      bus.CFG_EN = 1'b1; bus.CFG_DIN = 1'($urandom()); cyc();
    end
    RSTN = 1'b0;
    cyc();
    chk("rst_shift_done", bus.CFG_DONE, 1'b0);
    chk("rst_shift_q", bus.Q, 2'b00);
    chk("rst_shift_out", bus.OUT, 2'b00);
    RSTN = 1'b1; bus.CFG_EN = 1'b0;

    // Reset landing on the commit edge
    for (int k = 0; k < LEN; k++) begin
      bus.CFG_EN = 1'b1; bus.CFG_DIN = 1'b1; cyc();
    end
    bus.CFG_EN = 1'b0;
    RSTN = 1'b0;
    cyc();
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.IN = INW'($urandom()); bus.CE = NUM_SLICE'($urandom()); bus.SR = NUM_SLICE'($urandom());
      cyc();
      chk("rst_commit_out", bus.OUT, 2'b00);
      chk("rst_commit_done", bus.CFG_DONE, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
